// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
//   boothState_t : controller states (IDLE, CALC, DONE)
//   recodeMag_t  : magnitude selected by a Booth group (0, 1M, 2M)
//   recode_t     : recoder output {selZero, sel2x, neg}
//   nstepOf()    : number of radix-4 iterations for a given operand width
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } boothState_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    PM1  = 2'd1,
    PM2  = 2'd2
  } recodeMag_t;

  typedef struct packed {
    logic selZero;
    logic sel2x;
    logic neg;
  } recode_t;

  // Operands are extended by two bits, so WIDTH/2+1 groups cover all of Q.
  function automatic int unsigned nstepOf(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder.
//   grp : {q[i+1], q[i], q[i-1]} multiplier bit group
//   rec : {selZero, sel2x, neg} partial-product select
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] grp,
  output recode_t    rec
);

  recodeMag_t mag;
  logic       neg;

  // Group -> digit in {-2,-1,0,+1,+2}
  always_comb begin
    mag = ZERO;
    neg = 1'b0;
    case (grp)
      3'b001, 3'b010: mag = PM1;
      3'b011:         mag = PM2;
      3'b100: begin
        mag = PM2;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = PM1;
        neg = 1'b1;
      end
      default: ;
    endcase
  end

  assign rec = '{selZero: (mag == ZERO), sel2x: (mag == PM2), neg: neg};

endmodule

// File: rtl/booth_mult_r4.sv
// Radix-4 (modified) Booth sequential multiplier, signed or unsigned.
// Retires two multiplier bits per cycle; start/ready/done handshake with
// back-to-back issue from the DONE state.
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, sampled only while ready
//   signed_mode : 1 = two's-complement operands, 0 = unsigned
//   a_in, b_in  : multiplicand / multiplier, captured on accepted start
//   ready       : can accept start (IDLE or DONE)
//   busy        : computing (CALC)
//   done        : one-cycle pulse, product valid
//   product     : 2*WIDTH result, held until the next result lands
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned NSTEP = nstepOf(WIDTH);
  localparam int unsigned CNTW  = $clog2(NSTEP);
  localparam int unsigned QW    = WIDTH + 2;
  localparam int unsigned AW    = WIDTH + 3;
  localparam int unsigned SW    = AW + QW + 1;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : gBadWidth
    $error("booth_mult_r4: WIDTH must be even and >= 4");
  end

  boothState_t     state;
  logic [CNTW-1:0] cnt;
  logic [QW-1:0]   mReg;
  logic [QW-1:0]   qReg;
  logic            qm1;
  logic [AW-1:0]   accA;

  recode_t         rec;
  logic [AW-1:0]   mOne;
  logic [AW-1:0]   mTwo;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   sum;
  logic [SW-1:0]   shifted;
  logic [AW-1:0]   nextA;
  logic [QW-1:0]   nextQ;
  logic            nextQm1;

  // Operand extension to WIDTH+2 bits according to the mode
  function automatic logic [QW-1:0] extend(input logic [WIDTH-1:0] x, input logic sgn);
    return sgn ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  endfunction

  booth_r4_recoder uRecoder (
    .grp ({qReg[1], qReg[0], qm1}),
    .rec (rec)
  );

  // One radix-4 step: add the selected +/-M or +/-2M, then shift {A,Q,q-1} right by 2
  always_comb begin
    mOne    = {mReg[QW-1], mReg};
    mTwo    = {mReg, 1'b0};
    addend  = rec.selZero ? '0 : (rec.sel2x ? mTwo : mOne);
    addend  = rec.neg ? ~addend : addend;
    sum     = accA + addend + AW'(rec.neg);
    shifted = {{2{sum[AW-1]}}, sum, qReg, qm1} >> 2;
    nextA   = shifted[SW-1 -: AW];
    nextQ   = shifted[QW:1];
    nextQm1 = shifted[0];
  end

  // Controller and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      mReg    <= '0;
      qReg    <= '0;
      qm1     <= 1'b0;
      accA    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            ready <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            mReg  <= extend(a_in, signed_mode);
            qReg  <= extend(b_in, signed_mode);
            qm1   <= 1'b0;
            accA  <= '0;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        CALC: begin
          accA <= nextA;
          qReg <= nextQ;
          qm1  <= nextQm1;
          cnt  <= cnt + CNTW'(1);
          if (cnt == CNTW'(NSTEP - 1)) begin
            // After WIDTH+2 bits of shift {A,Q} is the exact product
            product <= {nextA[WIDTH-3:0], nextQ};
            state   <= DONE;
            done    <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_r4.sv
// Scoreboard bench for booth_mult_r4 at WIDTH=8 and WIDTH=16.
module tb_booth_mult_r4;

  localparam int NSTEP8  = 5;
  localparam int NSTEP16 = 9;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        ready8, busy8, done8;
  logic [15:0] product8;

  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic        ready16, busy16, done16;
  logic [31:0] product16;

  typedef struct {
    logic [31:0] want;
    int          acc;
    string       name;
  } exp_t;

  exp_t        q8[$];
  exp_t        q16[$];
  exp_t        eMon;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic        rstPrev  = 1'b0;
  logic [31:0] hold8    = '0;
  logic [31:0] hold16   = '0;
  bit          sawDone;

  booth_mult_r4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a_in(a8), .b_in(b8), .ready(ready8), .busy(busy8),
    .done(done8), .product(product8)
  );

  booth_mult_r4 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .a_in(a16), .b_in(b16), .ready(ready16), .busy(busy16),
    .done(done16), .product(product16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: reset state, scoreboard pops on done, product hold between results
  always @(negedge clk) begin
    if (rstPrev) begin
      chk("rst_ready8",   32'(ready8),   32'd1);
      chk("rst_busy8",    32'(busy8),    32'd0);
      chk("rst_done8",    32'(done8),    32'd0);
      chk("rst_product8", 32'(product8), 32'd0);
      chk("rst_ready16",  32'(ready16),  32'd1);
      chk("rst_product16", product16,    32'd0);
      hold8  = '0;
      hold16 = '0;
    end else if (!rst) begin
      if (done8) begin
        if (q8.size() == 0) begin
          chk("unexpected_done8", 32'(done8), 32'd0);
        end else begin
          eMon = q8.pop_front();
          chk({eMon.name, "_product"}, 32'(product8), eMon.want);
          chk({eMon.name, "_latency"}, 32'(cyc - eMon.acc), 32'(NSTEP8));
          chk({eMon.name, "_ready"},   32'(ready8), 32'd1);
          hold8 = eMon.want;
        end
      end else begin
        chk("hold8", 32'(product8), hold8);
      end
      if (done16) begin
        if (q16.size() == 0) begin
          chk("unexpected_done16", 32'(done16), 32'd0);
        end else begin
          eMon = q16.pop_front();
          chk({eMon.name, "_product"}, product16, eMon.want);
          chk({eMon.name, "_latency"}, 32'(cyc - eMon.acc), 32'(NSTEP16));
          hold16 = eMon.want;
        end
      end else begin
        chk("hold16", product16, hold16);
      end
    end
    rstPrev = rst;
  end

  // Wait for ready, present one request, push its expectation on acceptance
  task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] want, input string name, input bit push,
                        output bit doneAtIssue);
    int t;
    t = 0;
    doneAtIssue = 1'b0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!ready8 && t < 100);
    if (!ready8) begin
      chk({name, "_ready_timeout"}, 32'(ready8), 32'd1);
      return;
    end
    doneAtIssue = done8;
    start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    if (push) q8.push_back('{want: {16'h0, want}, acc: cyc, name: name});
    chk({name, "_busy"}, 32'(busy8), 32'd1);
    // Scramble inputs: they must not be resampled mid-operation
    sm8 = ~sm; a8 = ~a; b8 = ~b;
  endtask

  task automatic issue16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] want, input string name);
    int t;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!ready16 && t < 100);
    if (!ready16) begin
      chk({name, "_ready_timeout"}, 32'(ready16), 32'd1);
      return;
    end
    start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0;
    q16.push_back('{want: want, acc: cyc, name: name});
    sm16 = ~sm; a16 = ~a; b16 = ~b;
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [31:0] rw;
    logic        rs;
    int          t;

    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Signed and unsigned directed vectors, WIDTH=8
    issue8(1'b1, 8'h07, 8'hFD, 16'hFFEB, "s_7xm3", 1'b1, sawDone);
    issue8(1'b1, 8'h80, 8'h80, 16'h4000, "s_minxmin", 1'b1, sawDone);
    issue8(1'b1, 8'h80, 8'h7F, 16'hC080, "s_minxmax", 1'b1, sawDone);
    issue8(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_m1xm1", 1'b1, sawDone);
    repeat (3) @(posedge clk);
    issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ffxff", 1'b1, sawDone);
    issue8(1'b0, 8'h80, 8'h02, 16'h0100, "u_80x02", 1'b1, sawDone);
    issue8(1'b0, 8'hFF, 8'h01, 16'h00FF, "u_ffx01", 1'b1, sawDone);

    // start during CALC is ignored; then back-to-back issue from DONE
    issue8(1'b1, 8'h03, 8'h05, 16'h000F, "s_3x5", 1'b1, sawDone);
    @(posedge clk); #1;
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'h11; b8 = 8'h11;
    @(posedge clk); #1;
    start8 = 1'b0;
    issue8(1'b1, 8'h0A, 8'h0A, 16'h0064, "s_10x10", 1'b1, sawDone);
    chk("b2b_from_done", 32'(sawDone), 32'd1);

    // Reset in the third CALC cycle abandons the operation
    issue8(1'b1, 8'h7F, 8'h7F, 16'h3F01, "s_7fx7f_abandon", 1'b0, sawDone);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    issue8(1'b1, 8'h02, 8'h02, 16'h0004, "s_2x2", 1'b1, sawDone);

    // WIDTH=16 corners
    issue16(1'b1, 16'h0000, 16'hFFFF, 32'h00000000, "w16_s_0xm1");
    issue16(1'b1, 16'h0001, 16'hFFFF, 32'hFFFFFFFF, "w16_s_1xm1");
    issue16(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, "w16_s_m1xm1");
    issue16(1'b1, 16'h8000, 16'h8000, 32'h40000000, "w16_s_minxmin");
    issue16(1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, "w16_s_maxxmax");
    issue16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, "w16_s_minxmax");
    issue16(1'b1, 16'hFFFF, 16'h7FFF, 32'hFFFF8001, "w16_s_m1xmax");
    issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16_u_ffffxffff");
    issue16(1'b0, 16'h8000, 16'h8000, 32'h40000000, "w16_u_8000x8000");
    issue16(1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF, "w16_u_ffffx1");
    issue16(1'b0, 16'h7FFF, 16'hFFFF, 32'h7FFE8001, "w16_u_7fffxffff");
    issue16(1'b0, 16'h1234, 16'h5678, 32'h06260060, "w16_u_1234x5678");

    // WIDTH=16 random pairs against an arithmetic reference
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'(i & 1);
      if (rs) rw = 32'($signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb}));
      else    rw = {16'h0, ra} * {16'h0, rb};
      issue16(rs, ra, rb, rw, rs ? "w16_rand_s" : "w16_rand_u");
    end

    // Drain outstanding results with a bounded wait
    t = 0;
    while ((q8.size() != 0 || q16.size() != 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    chk("drain8",  32'(q8.size()),  32'd0);
    chk("drain16", 32'(q16.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
